// File: rtl/registrador_serial_tx.sv
// Parallel-in, serial-out byte transmitter: start 0, data LSB first, stop 1.
// Define REGISTRADOR_PARIDADE_EN to add an even-parity bit between data and stop.
module registrador_serial_tx #(
   parameter int unsigned CLKS_POR_BIT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] entrada,
   input  logic       entrada_valida,
   output logic       pronto,
   output logic       saida_serial,
   output logic       ocupado
);

   localparam int unsigned DIV_W = 8;
   localparam int unsigned BIT_W = 3;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_POR_BIT - 1);

`ifdef REGISTRADOR_PARIDADE_EN
   typedef enum logic [2:0] {
      OCIOSO,
      INICIO,
      DADOS,
      PARIDADE,
      PARADA
   } estado_t;
`else
   typedef enum logic [2:0] {
      OCIOSO,
      INICIO,
      DADOS,
      PARADA
   } estado_t;
`endif

   estado_t          estado_q, estado_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             saida_q, saida_d;
   logic             pronto_q, pronto_d;
   logic             ocupado_q, ocupado_d;
   logic             fim_bit;
`ifdef REGISTRADOR_PARIDADE_EN
   logic             paridade_q, paridade_d;
`endif

   // Next-state and next-output logic; outputs are derived from the next state.
   always_comb begin
      estado_d = estado_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
`ifdef REGISTRADOR_PARIDADE_EN
      paridade_d = paridade_q;
`endif
      fim_bit  = (div_q == DIV_MAX);

      // Every state change happens on fim_bit, so the wrap also realigns the divider.
      if (estado_q != OCIOSO) begin
         div_d = fim_bit ? '0 : div_q + DIV_W'(1);
      end

      case (estado_q)
         OCIOSO: begin
            if (entrada_valida && pronto_q) begin
               shift_d  = entrada;
               bit_d    = '0;
               div_d    = '0;
`ifdef REGISTRADOR_PARIDADE_EN
               paridade_d = ^entrada;
`endif
               estado_d = INICIO;
            end
         end
         INICIO: begin
            if (fim_bit) begin
               bit_d    = '0;
               estado_d = DADOS;
            end
         end
         DADOS: begin
            if (fim_bit) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == BIT_W'(7)) begin
`ifdef REGISTRADOR_PARIDADE_EN
                  estado_d = PARIDADE;
`else
                  estado_d = PARADA;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef REGISTRADOR_PARIDADE_EN
         PARIDADE: begin
            if (fim_bit) estado_d = PARADA;
         end
`endif
         PARADA: begin
            if (fim_bit) estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase

      case (estado_d)
         INICIO:   saida_d = 1'b0;
         DADOS:    saida_d = shift_d[0];
`ifdef REGISTRADOR_PARIDADE_EN
         PARIDADE: saida_d = paridade_d;
`endif
         default:  saida_d = 1'b1;
      endcase

      pronto_d  = (estado_d == OCIOSO);
      ocupado_d = (estado_d != OCIOSO);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q  <= OCIOSO;
         div_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         saida_q   <= 1'b1;
         pronto_q  <= 1'b1;
         ocupado_q <= 1'b0;
`ifdef REGISTRADOR_PARIDADE_EN
         paridade_q <= 1'b0;
`endif
      end else begin
         estado_q  <= estado_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         saida_q   <= saida_d;
         pronto_q  <= pronto_d;
         ocupado_q <= ocupado_d;
`ifdef REGISTRADOR_PARIDADE_EN
         paridade_q <= paridade_d;
`endif
      end
   end

   assign pronto       = pronto_q;
   assign saida_serial = saida_q;
   assign ocupado      = ocupado_q;

endmodule

// File: doc/registrador_serial_tx.md
Name: registrador_serial_tx

Overview:
- Parallel-in, serial-out byte transmitter: the reading end of the 8-bit parallel register path.
- Captures an 8-bit word from a register output over a valid/ready handshake, then shifts it out on a single line as an asynchronous-style frame.
- Frame: start 0, data LSB first, stop 1. Single clock domain; the line-rate divider is internal.

Parameters:
- CLKS_POR_BIT, default 4: clock cycles per serial bit. Legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- entrada  input  8  byte to transmit; sampled only on handshake
- entrada_valida  input  1  producer asserts when entrada holds a byte to send
- pronto  output  1  transmitter can accept a byte this cycle
- saida_serial  output  1  serial line; idles high
- ocupado  output  1  frame in progress (not OCIOSO)

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clock. When reset=1 at an edge:
  - saida_serial=1, pronto=1, ocupado=0
  - state=OCIOSO; bit counter, divider counter and shift register cleared to 0
- Reset has priority over every other event, including a mid-frame transfer. The frame is aborted with no partial stop bit; the line is 1 from the cycle after reset.
- Handshake:
  - A transfer occurs at an edge where entrada_valida=1 and pronto=1.
  - pronto is registered and is 1 only in OCIOSO.
  - entrada is ignored at all other times; valid without pronto is a no-op, and the producer holds the byte.
- States:
  - OCIOSO: line 1. On transfer, latch entrada into the shift register and go to INICIO.
  - INICIO: line 0 for CLKS_POR_BIT cycles, then go to DADOS with bit index 0.
  - DADOS: line = shift[0] for CLKS_POR_BIT cycles per bit. Shift right after each bit. After bit index 7 completes, go to PARADA (or PARIDADE, see Optional Feature).
  - PARADA: line 1 for CLKS_POR_BIT cycles, then go to OCIOSO.
- Timing:
  - Handshake edge N. From cycle N+1: pronto=0, ocupado=1, saida_serial=0.
  - Frame length is exactly 10*CLKS_POR_BIT cycles (N+1 .. N+10*CLKS_POR_BIT).
  - pronto=1 and ocupado=0 in cycle N+10*CLKS_POR_BIT+1.
- Back-to-back:
  - Earliest next handshake is the edge ending the OCIOSO cycle, so frames are separated by at least 1 idle-high cycle.
  - Net minimum period is 10*CLKS_POR_BIT+1 cycles.
- Divider:
  - Counts 0..CLKS_POR_BIT-1 and resets to 0 on every state change.
  - With CLKS_POR_BIT=1 every bit lasts exactly one cycle.
- Bit counter: 3 bits. Wrap after bit 7 is not used; the state exits first.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: REGISTRADOR_PARIDADE_EN.
- Defined:
  - Adds state PARIDADE between DADOS and PARADA.
  - Drives the even-parity bit (XOR of the 8 latched data bits) for CLKS_POR_BIT cycles.
  - Frame becomes 11*CLKS_POR_BIT cycles; pronto returns at N+11*CLKS_POR_BIT+1.
- Undefined: no PARIDADE state and no parity logic; frame as above.

Test Plan:
- Reset, then idle 20 cycles -> saida_serial=1, pronto=1, ocupado=0 throughout.
- CLKS_POR_BIT=4, send 8'hA5 -> line sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1. pronto low for exactly 40 cycles, high on cycle 41.
- entrada_valida held 1 with 8'h3C then 8'hC3 -> two frames separated by exactly 1 idle-high cycle. Second frame carries C3. Changing entrada mid-frame has no effect.
- Reset asserted at cycle 15 of an 8'hFF frame -> next cycle line=1, pronto=1, ocupado=0. A following 8'h00 frame is transmitted intact.
- CLKS_POR_BIT=1, send 8'h01 -> line 0,1,0,0,0,0,0,0,0,1 on consecutive cycles; pronto high in cycle 11.
- With REGISTRADOR_PARIDADE_EN, CLKS_POR_BIT=4:
  - Send 8'h07 -> parity slot=1, frame 44 cycles.
  - Send 8'h03 -> parity slot=0.
